// File: rtl/full_adder_checker.sv
// Stimulus/response checker for a 1-bit full adder: drives all eight {a,b,cin}
// vectors, samples sum/carry after a settle time and reports pass/fail results.
module full_adder_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             cin,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic             fail_valid,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Last value of the settle counter; unused when there is no settle phase.
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t           state, state_n;
    logic [2:0]       v, v_n;
    logic [3:0]       cnt, cnt_n;
    logic [2:0]       stim, stim_n;
    logic             busy_n, done_n, pass_n, fail_valid_n;
    logic [ERR_W-1:0] err_n;
    logic [2:0]       fail_vec_n;
    logic             exp_sum, exp_carry, mismatch;

    assign {a, b, cin} = stim;
    assign state_dbg   = state;

    // Expectation is derived from the registered stimulus, which equals v while sampling.
    assign exp_sum   = a ^ b ^ cin;
    assign exp_carry = (a & b) | (a & cin) | (b & cin);
    assign mismatch  = (sum != exp_sum) || (carry != exp_carry);

    always_comb begin
        state_n      = state;
        v_n          = v;
        cnt_n        = cnt;
        stim_n       = stim;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        err_n        = err_count;
        fail_vec_n   = fail_vec;
        fail_valid_n = fail_valid;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n      = DRIVE;
                    v_n          = 3'd0;
                    err_n        = '0;
                    fail_vec_n   = 3'd0;
                    fail_valid_n = 1'b0;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    busy_n       = 1'b1;
                end
            end
            DRIVE: begin
                stim_n  = v;
                cnt_n   = 4'd0;
                state_n = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_n = err_count + 1'b1;
                    end
                    if (!fail_valid) begin
                        fail_vec_n   = v;
                        fail_valid_n = 1'b1;
                    end
                end
                if (v == 3'd7) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                end else begin
                    v_n     = v + 3'd1;
                    state_n = DRIVE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v          <= 3'd0;
            cnt        <= 4'd0;
            stim       <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 3'd0;
            fail_valid <= 1'b0;
        end else begin
            state      <= state_n;
            v          <= v_n;
            cnt        <= cnt_n;
            stim       <= stim_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
            fail_vec   <= fail_vec_n;
            fail_valid <= fail_valid_n;
        end
    end

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker: three instances (default, ERR_W=2, SETTLE_CYCLES=0)
// each wired to a small adder model with selectable faults.
module tb_full_adder_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [3];
    logic [1:0] mode [3];   // 0: correct adder, 1: carry stuck at 0, 2: sum inverted

    logic [2:0] abc_s [3];
    logic       busy_s [3];
    logic       done_s [3];
    logic       pass_s [3];
    logic       fval_s [3];
    logic [2:0] fvec_s [3];
    logic [3:0] ec_s [3];
    logic [2:0] st_s [3];

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    logic [8:0] exp_q [$];
    logic [2:0] trace [0:63];
    logic       k_busy, k_done;
    logic [8:0] k_rec;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = (g == 2) ? 0 : 2;
        localparam int EW = (g == 1) ? 2 : 4;
        logic          a, b, cin, sum, carry, busy, done, pass, fail_valid;
        logic [EW-1:0] err_count;
        logic [2:0]    fail_vec, state_dbg;

        assign sum   = a ^ b ^ cin ^ (mode[g] == 2'd2);
        assign carry = (mode[g] == 2'd1) ? 1'b0 : ((a & b) | (a & cin) | (b & cin));

        full_adder_checker #(.SETTLE_CYCLES(ST), .ERR_W(EW)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]),
            .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
            .busy(busy), .done(done), .pass(pass), .err_count(err_count),
            .fail_vec(fail_vec), .fail_valid(fail_valid), .state_dbg(state_dbg)
        );

        assign abc_s[g]  = {a, b, cin};
        assign busy_s[g] = busy;
        assign done_s[g] = done;
        assign pass_s[g] = pass;
        assign fval_s[g] = fail_valid;
        assign fvec_s[g] = fail_vec;
        assign ec_s[g]   = 4'(err_count);
        assign st_s[g]   = state_dbg;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_s[i] && done_s[i]) overlap++;
        end
    end

    // Reference result {pass, fail_valid, fail_vec, err_count} for a fault mode.
    function automatic logic [8:0] model_result(input int fmode, input int errw);
        int         err = 0;
        int         maxe = (1 << errw) - 1;
        logic       fv_ok = 1'b0;
        logic [2:0] fv = 3'd0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec = 3'(v);
            int   ones = int'(vec[0]) + int'(vec[1]) + int'(vec[2]);
            logic good_s = ones[0];
            logic good_c = (ones >= 2);
            logic dut_s = good_s ^ (fmode == 2);
            logic dut_c = (fmode == 1) ? 1'b0 : good_c;
            if (dut_s != good_s || dut_c != good_c) begin
                if (err < maxe) err++;
                if (!fv_ok) begin
                    fv_ok = 1'b1;
                    fv    = vec;
                end
            end
        end
        return {(err == 0), fv_ok, fv, 4'(err)};
    endfunction

    function automatic logic [8:0] observed(input int g);
        return {pass_s[g], fval_s[g], fvec_s[g], ec_s[g]};
    endfunction

    // Pulses start, records stimulus after each edge until done (bounded).
    task automatic run_collect(input int g, input int repulse_at, output int cycles);
        cycles = 0;
        for (int i = 0; i < 64; i++) trace[i] = 3'bxxx;
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
        k_busy = busy_s[g];
        k_done = done_s[g];
        k_rec  = observed(g);
        while (!done_s[g] && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles < 64) trace[cycles] = abc_s[g];
            start[g] = (cycles == repulse_at);
        end
        start[g] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({observed(g), abc_s[g], busy_s[g], done_s[g], st_s[g]} !== 17'd0) begin
                errors++;
                $display("FAIL reset_values[%0d]: got rec=%h abc=%b busy=%b done=%b st=%0d, expected all 0",
                         g, observed(g), abc_s[g], busy_s[g], done_s[g], st_s[g]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_run();
        int cyc, bad;
        logic [8:0] exp;
        mode[0] = 2'd0;
        exp_q.push_back(model_result(0, 4));
        run_collect(0, 0, cyc);
        checks++;
        if (k_busy !== 1'b1) begin
            errors++; $display("FAIL pass_busy_after_start: got %b expected 1", k_busy);
        end
        checks++;
        if (cyc != 32) begin
            errors++; $display("FAIL pass_run_length: got %0d expected 32", cyc);
        end
        bad = -1;
        for (int c = 1; c <= 32; c++) if (trace[c] !== 3'((c - 1) / 4) && bad < 0) bad = c;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL pass_vector_seq: cycle %0d got %b expected %b", bad, trace[bad], 3'((bad - 1) / 4));
        end
        exp = exp_q.pop_front();
        checks++;
        if (observed(0) !== exp) begin
            errors++; $display("FAIL pass_result: got %h expected %h", observed(0), exp);
        end
        checks++;
        if ({abc_s[0], busy_s[0]} !== 4'b1110) begin
            errors++; $display("FAIL pass_end_state: got abc=%b busy=%b expected abc=111 busy=0", abc_s[0], busy_s[0]);
        end
    endtask

    task automatic test_carry_stuck();
        int cyc;
        logic [8:0] exp;
        mode[0] = 2'd1;
        exp_q.push_back(model_result(1, 4));
        run_collect(0, 0, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc != 32) begin
            errors++; $display("FAIL carry_run_length: got %0d expected 32", cyc);
        end
        checks++;
        if (observed(0) !== exp) begin
            errors++; $display("FAIL carry_result: got %h expected %h", observed(0), exp);
        end
    endtask

    task automatic test_rerun();
        int cyc, cyc2, bad;
        logic [8:0] exp;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done_s[0], busy_s[0]} !== 2'b10) begin
            errors++; $display("FAIL done_hold: got done=%b busy=%b expected done=1 busy=0", done_s[0], busy_s[0]);
        end
        mode[0] = 2'd0;
        exp_q.push_back(model_result(0, 4));
        run_collect(0, 0, cyc);
        checks++;
        if ({k_busy, k_done, k_rec} !== {2'b10, 9'd0}) begin
            errors++; $display("FAIL rerun_clear: got busy=%b done=%b rec=%h expected busy=1 done=0 rec=000", k_busy, k_done, k_rec);
        end
        exp = exp_q.pop_front();
        checks++;
        if (observed(0) !== exp || cyc != 32) begin
            errors++; $display("FAIL rerun_result: got %h in %0d cycles expected %h in 32", observed(0), cyc, exp);
        end
        exp_q.push_back(model_result(0, 4));
        run_collect(0, 0, cyc2);
        exp = exp_q.pop_front();
        bad = -1;
        for (int c = 1; c <= 32; c++) if (trace[c] !== 3'((c - 1) / 4) && bad < 0) bad = c;
        checks++;
        if (observed(0) !== exp || cyc2 != 32 || bad >= 0) begin
            errors++; $display("FAIL rerun_identical: got %h cycles=%0d badcyc=%0d expected %h cycles=32 badcyc=-1", observed(0), cyc2, bad, exp);
        end
    endtask

    task automatic test_restart_ignored();
        int cyc;
        logic [8:0] exp;
        mode[0] = 2'd0;
        exp_q.push_back(model_result(0, 4));
        run_collect(0, 18, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc != 32) begin
            errors++; $display("FAIL restart_ignored_length: got %0d expected 32", cyc);
        end
        checks++;
        if (observed(0) !== exp) begin
            errors++; $display("FAIL restart_ignored_result: got %h expected %h", observed(0), exp);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        logic [8:0] exp;
        mode[1] = 2'd2;
        exp_q.push_back(model_result(2, 2));
        run_collect(1, 0, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (observed(1) !== exp || cyc != 32) begin
            errors++; $display("FAIL saturate_result: got %h in %0d cycles expected %h in 32", observed(1), cyc, exp);
        end
    endtask

    task automatic test_settle0();
        int cyc, bad;
        logic [8:0] exp;
        mode[2] = 2'd0;
        exp_q.push_back(model_result(0, 4));
        run_collect(2, 0, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc != 16) begin
            errors++; $display("FAIL settle0_length: got %0d expected 16", cyc);
        end
        bad = -1;
        for (int c = 1; c <= 16; c++) if (trace[c] !== 3'((c - 1) / 2) && bad < 0) bad = c;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL settle0_hold: cycle %0d got %b expected %b", bad, trace[bad], 3'((bad - 1) / 2));
        end
        checks++;
        if (observed(2) !== exp) begin
            errors++; $display("FAIL settle0_result: got %h expected %h", observed(2), exp);
        end
    endtask

    task automatic test_start_held();
        int cyc = 0;
        @(negedge clk);
        start[2] = 1'b1;
        @(posedge clk);
        #1;
        while (!done_s[2] && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 16) begin
            errors++; $display("FAIL held_length: got %0d expected 16", cyc);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done_s[2], busy_s[2]} !== 2'b01) begin
            errors++; $display("FAIL held_one_cycle_done: got done=%b busy=%b expected done=0 busy=1", done_s[2], busy_s[2]);
        end
        start[2] = 1'b0;
        cyc = 0;
        while (!done_s[2] && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset_midrun();
        int cyc = 0;
        logic [8:0] exp;
        mode[0] = 2'd1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        while (abc_s[0] !== 3'd5 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (ec_s[0] !== 4'd1 || cyc != 21) begin
            errors++; $display("FAIL midrun_before_reset: got err=%0d at cycle %0d expected err=1 at cycle 21", ec_s[0], cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({observed(0), abc_s[0], busy_s[0], done_s[0], st_s[0]} !== 17'd0) begin
            errors++; $display("FAIL midrun_async_reset: got rec=%h abc=%b busy=%b done=%b st=%0d expected all 0",
                               observed(0), abc_s[0], busy_s[0], done_s[0], st_s[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model_result(1, 4));
        run_collect(0, 0, cyc);
        exp = exp_q.pop_front();
        checks++;
        if (observed(0) !== exp || cyc != 32) begin
            errors++; $display("FAIL midrun_fresh_run: got %h in %0d cycles expected %h in 32", observed(0), cyc, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            mode[i]  = 2'd0;
        end
        test_reset();
        test_pass_run();
        test_carry_stuck();
        test_rerun();
        test_restart_ignored();
        test_saturate();
        test_settle0();
        test_start_held();
        test_reset_midrun();
        checks++;
        if (overlap != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL busy_done_overlap: got %0d overlap cycles, %0d queued expects; expected 0 and 0", overlap, exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/full_adder_checker.md
# full_adder_checker

Self-checking stimulus/response block for the 1-bit full adder on the Alchitry Cu. It sits at the opposite end of the adder's interface from a static input probe: it drives all eight `{a,b,cin}` combinations in sequence and samples `sum`/`carry` after a programmable settle time. It compares each sample against the arithmetic expectation and reports pass/fail, an error count and the first failing vector, for display on board LEDs.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles between driving a vector and sampling the response. Legal range 0..15.
- `ERR_W`, default 4: width of the error counter.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level; sampled in IDLE or DONE to begin a run.
- `a`, `b`, `cin`  out  1 each  registered stimulus to the adder under test.
- `sum`, `carry`  in  1 each  adder response; synchronous to `clk`, combinational from `a`/`b`/`cin`.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next run starts.
- `pass`  out  1  high when `done` is high and `err_count` is 0.
- `err_count`  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- `fail_vec`  out  3  first failing vector `{a,b,cin}`.
- `fail_valid`  out  1  `fail_vec` holds a captured mismatch.

## Operation
- Vector index `v[2:0]` maps to `{a,b,cin}`, stepping 0 to 7 in ascending order.
- Expected results: `exp_sum = a^b^cin`; `exp_carry = (a&b)|(a&cin)|(b&cin)`.
- Mismatch: `(sum != exp_sum) || (carry != exp_carry)`. A vector with both outputs wrong counts as one error.
- States and transitions:
  - IDLE: `start` = 1 goes to DRIVE.
  - DRIVE: goes to SETTLE, or to SAMPLE if `SETTLE_CYCLES` = 0.
  - SETTLE: goes to SAMPLE after `SETTLE_CYCLES` cycles.
  - SAMPLE: goes to DONE if `v` = 7, otherwise increments `v` and goes to DRIVE.
  - DONE: `start` = 1 goes to DRIVE.
- Run start, from IDLE or DONE: clear `v`, `err_count`, `fail_vec`, `fail_valid`, `done`, `pass`; set `busy`.
- DRIVE: registers `{a,b,cin} <= v`. Stimulus is held stable through SETTLE and SAMPLE.
- SAMPLE: on a mismatch, `err_count` increments (saturating). If `fail_valid` = 0, capture `fail_vec <= v` and set `fail_valid`.
- Entering DONE: `busy` = 0, `done` = 1, `pass` = (final `err_count` == 0). Stimulus stays at vector 7.
- `start` while `busy` is ignored. No restart and no abort.
- `start` held high continuously: a new run begins each time DONE is entered. DONE lasts exactly one cycle in that case.

## Timing
- Reset values:
  - `a` = `b` = `cin` = 0
  - `busy` = 0, `done` = 0, `pass` = 0
  - `err_count` = 0, `fail_vec` = 0, `fail_valid` = 0
  - state IDLE, `v` = 0
- Reset is asynchronous; assertion mid-run returns every output to its reset value immediately. Deassertion is synchronised to `clk` by the integrator.
- `start` high at edge k: `busy` = 1 after edge k.
  - The DRIVE edge k+1 puts vector 0 on `a`/`b`/`cin`.
  - From then on the inputs are valid on every cycle.
- Each vector occupies `SETTLE_CYCLES` + 2 cycles (DRIVE, SETTLE×N, SAMPLE).
- `sum`/`carry` are sampled on the closing edge of SAMPLE, which is `SETTLE_CYCLES` + 1 edges after that vector was driven.
- Run length from the first DRIVE edge to `done` = 1 is 8×(`SETTLE_CYCLES`+2) cycles. This is 32 cycles at the default and 16 cycles at 0.
- `busy` and `done` are never high together.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
- Correct gate-level adder, defaults, `start` pulsed 1 cycle → `done` 32 cycles after the first DRIVE; `pass` = 1, `err_count` = 0, `fail_valid` = 0; `a`/`b`/`cin` end at 1/1/1.
- Adder with `carry` stuck at 0 → mismatches at vectors 3, 5, 6, 7; `err_count` = 4, `fail_vec` = 3'b011, `fail_valid` = 1, `pass` = 0.
- Adder with `sum` inverted, `ERR_W` = 2 → 8 mismatches saturate at `err_count` = 3; `fail_vec` = 0, `fail_valid` = 1, `pass` = 0.
- `SETTLE_CYCLES` = 0, correct adder → run completes in 16 cycles, `pass` = 1. Check that each vector is held exactly 2 cycles.
- `start` re-pulsed mid-run (vector 4) → no restart; `done` still arrives at cycle 32. A `start` after DONE clears the results and reruns identically.
- `rst_n` low at vector 5 of a failing run → all outputs return to reset values at once; a subsequent `start` gives a fresh run with `err_count` counted from 0.
